// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the IF/MEM single-port memory arbiter.
package mem_arbiter_pkg;

   localparam int unsigned CPU_ADDR_W = 16;
   localparam int unsigned CPU_DATA_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      IRD,
      DRD,
      DWR,
      DONE
   } arb_state_e;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_DM = 1'b1
   } grant_e;

   // Latency down-counter width: must hold the value MEM_LAT itself.
   function automatic int unsigned lat_cnt_w(input int unsigned lat);
      return $clog2(lat + 1);
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch/data request ports plus the memory macro port of the arbiter.
interface mem_arbiter_if #(
   parameter int unsigned ADDR_W = mem_arbiter_pkg::CPU_ADDR_W,
   parameter int unsigned DATA_W = mem_arbiter_pkg::CPU_DATA_W
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_rdy;
   logic [DATA_W-1:0] if_instr;

   logic              dm_re;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_rdy;
   logic [DATA_W-1:0] dm_rdata;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_re;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              stall_if;
   logic              stall_mem;

   modport slave (
      input  if_req, if_addr, dm_re, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_rdy, if_instr, dm_rdy, dm_rdata,
             mem_addr, mem_re, mem_we, mem_wdata, stall_if, stall_mem
   );

   modport master (
      output if_req, if_addr, dm_re, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_rdy, if_instr, dm_rdy, dm_rdata,
             mem_addr, mem_re, mem_we, mem_wdata, stall_if, stall_mem
   );

endinterface

// File: rtl/mem_arbiter_stats.sv
// Saturating stall-cycle counters for the fetch and data ports.
module mem_arbiter_stats #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_if,
   input  logic             stall_mem,
   output logic [CNT_W-1:0] stat_if_stall,
   output logic [CNT_W-1:0] stat_mem_stall
);

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_if_stall  <= '0;
         stat_mem_stall <= '0;
      end else begin
         if (stall_if && (stat_if_stall != '1))
            stat_if_stall <= stat_if_stall + CNT_W'(1);
         if (stall_mem && (stat_mem_stall != '1))
            stat_mem_stall <= stat_mem_stall + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter serialising IF fetches and MEM loads/stores.
// Define MEM_ARBITER_STATS_EN to add the stat_if_stall/stat_mem_stall counters.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W  = CPU_ADDR_W,
   parameter int unsigned DATA_W  = CPU_DATA_W,
   parameter int unsigned MEM_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   mem_arbiter_if.slave bus
`ifdef MEM_ARBITER_STATS_EN
   ,
   output logic [15:0] stat_if_stall,
   output logic [15:0] stat_mem_stall
`endif
);

   localparam int unsigned CNT_W = lat_cnt_w(MEM_LAT);

   arb_state_e        state_q, state_d;
   grant_e            last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              re_q, re_d;
   logic              we_q, we_d;
   logic              if_rdy_q, if_rdy_d;
   logic              dm_rdy_q, dm_rdy_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic dm_req;
   logic fetch_win;

   assign dm_req    = bus.dm_re | bus.dm_we;
   // Data normally wins; a pending fetch wins right after a data grant.
   assign fetch_win = bus.if_req & (~dm_req | (last_q == GNT_DM));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         last_q   <= GNT_IF;
         cnt_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         re_q     <= 1'b0;
         we_q     <= 1'b0;
         if_rdy_q <= 1'b0;
         dm_rdy_q <= 1'b0;
         instr_q  <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         re_q     <= re_d;
         we_q     <= we_d;
         if_rdy_q <= if_rdy_d;
         dm_rdy_q <= dm_rdy_d;
         instr_q  <= instr_d;
         rdata_q  <= rdata_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      re_d     = 1'b0;
      we_d     = 1'b0;
      if_rdy_d = 1'b0;
      dm_rdy_d = 1'b0;
      instr_d  = instr_q;
      rdata_d  = rdata_q;

      case (state_q)
         IDLE: begin
            if (fetch_win) begin
               state_d = IRD;
               last_d  = GNT_IF;
               addr_d  = bus.if_addr;
               re_d    = 1'b1;
               cnt_d   = CNT_W'(MEM_LAT);
            end else if (dm_req) begin
               last_d = GNT_DM;
               addr_d = bus.dm_addr;
               // A simultaneous read strobe is dropped in favour of the store.
               if (bus.dm_we) begin
                  state_d = DWR;
                  we_d    = 1'b1;
                  wdata_d = bus.dm_wdata;
               end else begin
                  state_d = DRD;
                  re_d    = 1'b1;
                  cnt_d   = CNT_W'(MEM_LAT);
               end
            end
         end
         IRD, DRD: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = DONE;
               cnt_d   = '0;
               if (state_q == IRD) begin
                  instr_d  = bus.mem_rdata;
                  if_rdy_d = 1'b1;
               end else begin
                  rdata_d  = bus.mem_rdata;
                  dm_rdy_d = 1'b1;
               end
            end else begin
               re_d  = 1'b1;
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DWR: begin
            state_d  = DONE;
            dm_rdy_d = 1'b1;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_re    = re_q;
   assign bus.mem_we    = we_q;
   assign bus.if_rdy    = if_rdy_q;
   assign bus.dm_rdy    = dm_rdy_q;
   assign bus.if_instr  = instr_q;
   assign bus.dm_rdata  = rdata_q;
   assign bus.stall_if  = bus.if_req & ~if_rdy_q;
   assign bus.stall_mem = dm_req & ~dm_rdy_q;

`ifdef MEM_ARBITER_STATS_EN
   mem_arbiter_stats #(.CNT_W(16)) u_stats (
      .clk            (clk),
      .rst            (rst),
      .stall_if       (bus.stall_if),
      .stall_mem      (bus.stall_mem),
      .stat_if_stall  (stat_if_stall),
      .stat_mem_stall (stat_mem_stall)
   );
`endif

endmodule
